// File: rtl/matmul_pkg.sv
// Shared state encoding, latency limits and width helper for the matmul sequencer.
package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/valid_delay.sv
// Fixed-depth shift register aligning read strobes with returned memory data.
module valid_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sr_q [DEPTH];
  logic [W-1:0] sr_d [DEPTH];

  always_comb begin
    sr_d[0] = flush ? '0 : din;
    for (int s = 1; s < DEPTH; s++) begin
      sr_d[s] = flush ? '0 : sr_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) sr_q[s] <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) sr_q[s] <= sr_d[s];
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/matmul_sequencer.sv
// Element-at-a-time control sequencer for C = A*B: issues A/B reads, MAC strobes and C writes.
// state | meaning
// IDLE  | waiting for start, all strobes low
// ISSUE | one A/B read per cycle, k = 0..K-1
// DRAIN | RD_LAT cycles waiting for the last read data to reach the MAC
// STORE | write the accumulator to C, advance to the next element
// DONE  | one-cycle completion pulse
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int M      = 4,
  parameter int N      = 4,
  parameter int K      = 4,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              rd_en,
  output logic              mac_en,
  output logic              mac_first,
  output logic [ADDR_W-1:0] c_addr,
  output logic              c_we,
  output logic              busy,
  output logic              done
);

  localparam int KW = clog2_min1(K);
  localparam int IW = clog2_min1(M);
  localparam int JW = clog2_min1(N);
  localparam int LW = clog2_min1(RD_LAT + 1);
  localparam int MAX_ADDR = ((M * K > K * N) ? ((M * K > M * N) ? M * K : M * N)
                                             : ((K * N > M * N) ? K * N : M * N)) - 1;

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("matmul_sequencer: RD_LAT must be within 1..4");
  end
  if (MAX_ADDR >= (1 << ADDR_W)) begin : g_bad_addr_w
    $error("matmul_sequencer: ADDR_W too narrow for the matrix dimensions");
  end
  if (M < 1 || N < 1 || K < 1) begin : g_bad_dim
    $error("matmul_sequencer: M, N and K must all be at least 1");
  end

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [IW-1:0]     i_q, i_d;
  logic [JW-1:0]     j_q, j_d;
  logic [LW-1:0]     drn_q, drn_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;
  logic [ADDR_W-1:0] c_addr_q, c_addr_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    i_d      = i_q;
    j_d      = j_q;
    drn_d    = drn_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    c_addr_d = c_addr_q;
    a_base_d = a_base_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ISSUE;
          k_d      = '0;
          i_d      = '0;
          j_d      = '0;
          a_addr_d = '0;
          b_addr_d = '0;
          c_addr_d = '0;
          a_base_d = '0;
        end
      end
      ST_ISSUE: begin
        if (k_q == KW'(K - 1)) begin
          k_d     = '0;
          drn_d   = LW'(RD_LAT);
          state_d = ST_DRAIN;
        end else begin
          k_d      = k_q + KW'(1);
          a_addr_d = a_addr_q + ADDR_W'(1);
          b_addr_d = b_addr_q + ADDR_W'(N);
        end
      end
      ST_DRAIN: begin
        drn_d = drn_q - LW'(1);
        if (drn_q == LW'(1)) state_d = ST_STORE;
      end
      ST_STORE: begin
        if (j_q == JW'(N - 1) && i_q == IW'(M - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_ISSUE;
          c_addr_d = c_addr_q + ADDR_W'(1);
          if (j_q == JW'(N - 1)) begin
            j_d      = '0;
            i_d      = i_q + IW'(1);
            a_base_d = a_base_q + ADDR_W'(K);
            a_addr_d = a_base_q + ADDR_W'(K);
            b_addr_d = '0;
          end else begin
            j_d      = j_q + JW'(1);
            a_addr_d = a_base_q;
            b_addr_d = ADDR_W'(j_q) + ADDR_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      drn_q    <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      a_base_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      i_q      <= i_d;
      j_q      <= j_d;
      drn_q    <= drn_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      c_addr_q <= c_addr_d;
      a_base_q <= a_base_d;
    end
  end

  assign rd_en  = (state_q == ST_ISSUE);
  assign c_we   = (state_q == ST_STORE);
  assign done   = (state_q == ST_DONE);
  assign busy   = (state_q != ST_IDLE);
  assign a_addr = a_addr_q;
  assign b_addr = b_addr_q;
  assign c_addr = c_addr_q;

  // {mac_en, mac_first} is {rd_en, first term} delayed to match memory latency.
  valid_delay #(
    .DEPTH (RD_LAT),
    .W     (2)
  ) u_valid_delay (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .din   ({rd_en, rd_en && (k_q == '0)}),
    .dout  ({mac_en, mac_first})
  );

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Parametrised control sequencer for the matrix-multiply datapath. It computes C[M×N] = A[M×K] · B[K×N] one output element at a time. For each element it generates read addresses into the A and B buffers and issues latency-aligned MAC enable and first-term strobes. It then writes the finished accumulator to the C buffer. It sits between the top-level start/done handshake and the A/B/C memories plus the MAC unit, with configurable dimensions, memory read latency, abort, and automatic return to idle.

## Interface
- M, 4: rows of A and C (≥1)
- N, 4: columns of B and C (≥1)
- K, 4: inner dimension (≥1)
- RD_LAT, 1: A/B memory read latency in cycles (1..4; 0 is illegal and must be rejected by elaboration check)
- ADDR_W, 8: address width; must hold max(M·K, K·N, M·N)−1

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a multiplication; sampled only in IDLE
- abort  in  1  cancel the current operation; sampled in every state
- a_addr  out  ADDR_W  A read address, row-major, i·K+k
- b_addr  out  ADDR_W  B read address, row-major, k·N+j
- rd_en  out  1  A/B read strobe, high on each issue cycle
- mac_en  out  1  accumulate strobe, aligned with returned A/B data
- mac_first  out  1  with mac_en, MAC loads the product instead of adding it
- c_addr  out  ADDR_W  C write address, i·N+j
- c_we  out  1  C write strobe
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, ISSUE, DRAIN, STORE, DONE.
- IDLE: all strobes low. start=1 → ISSUE; i, j and k are cleared.
- ISSUE: rd_en=1; a_addr and b_addr reflect (i,j,k); k increments each cycle. At k=K−1 → DRAIN with a drain counter of RD_LAT.
- DRAIN: lasts exactly RD_LAT cycles, with no reads issued, then → STORE.
- STORE: c_we=1, c_addr=i·N+j. Then j increments; on wrap, j=0 and i increments. Then → ISSUE, or → DONE after element (M−1, N−1).
- DONE: done=1 for one cycle, then → IDLE unconditionally.
- mac_en and mac_first are the ISSUE-cycle rd_en and (k==0) delayed by exactly RD_LAT cycles through a shift register.
- Addresses use incrementing base registers, not multipliers:
  - a_base advances by K per row.
  - b_addr advances by N per k step.
  - c_addr advances by 1 per element.
- No counter wraps past its dimension.
- K=1: mac_first and the single mac_en coincide; ISSUE lasts 1 cycle.
- abort=1 takes priority over every transition. Next state is IDLE. The delay line is flushed, so no further mac_en appears. c_we and done are not asserted. abort in IDLE has no effect.
- start in any non-IDLE state is ignored. If start is held high, a new run begins on the cycle after DONE returns to IDLE.
- rst (asynchronous) forces IDLE and clears all counters and the delay line.
- Output reset values: all outputs 0, including the addresses.

## Timing
- Cycle 0 is the edge at which start is sampled in IDLE. The first ISSUE cycle is cycle 1.
- Per element: K ISSUE + RD_LAT DRAIN + 1 STORE cycles.
- The last mac_en of an element falls on the final DRAIN cycle. The accumulator is valid in the STORE cycle.
- done is high in cycle M·N·(K+RD_LAT+1)+1. busy is high in cycles 1 through that cycle inclusive.
- All outputs are decoded from registered state and counters only; there are no combinational input→output paths except none.
- Memories must return data exactly RD_LAT cycles after rd_en. The MAC must register its result on each mac_en edge.

## Structure
- Package matmul_pkg holds:
  - the state encoding constants (IDLE=0, ISSUE=1, DRAIN=2, STORE=3, DONE=4);
  - the RD_LAT legal-range constants;
  - a clog2 helper used for counter widths.
- Sub-module valid_delay (parameter DEPTH=RD_LAT, width 2) carries {rd_en, k==0} to {mac_en, mac_first}. It has a synchronous flush input driven on abort and an async clear on rst.

## Test plan
- M=N=K=2, RD_LAT=1, single start → a_addr sequence 0,1,0,1,2,3,2,3; b_addr sequence 0,2,1,3,0,2,1,3; c_we at c_addr 0,1,2,3; done in cycle 17 only.
- M=N=2, K=3, RD_LAT=2 → mac_en trails rd_en by exactly 2 cycles; mac_first on every third mac_en; first c_we in cycle 6; done in cycle 25.
- K=1, M=1, N=3, RD_LAT=1 → each element spans 3 cycles; mac_en and mac_first coincide; c_addr 0,1,2; done in cycle 10.
- abort in cycle 4 of the 2×2×2 case → IDLE at the next edge; no mac_en after abort; no further c_we; done never asserts; busy low.
- start pulsed mid-run, then held high through DONE → no restart mid-run; a second run begins one cycle after done, with a_addr=0.
- rst asserted asynchronously mid-DRAIN → all outputs 0 immediately; after release, the block stays in IDLE until the next start.
